// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit: access-size encodings, FSM
// state encodings and a helper returning the byte count of an access size.
// ---------------------------------------------------------------------------
package lsu_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } lsu_size_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } lsu_state_t;

   // Bytes touched by an access. The reserved size faults before it is used,
   // so its value here only has to keep the range arithmetic well defined.
   function automatic logic [2:0] size_bytes(input lsu_size_t i_size);
      logic [2:0] w_bytes;
      case (i_size)
         SZ_BYTE: w_bytes = 3'd1;
         SZ_HALF: w_bytes = 3'd2;
         default: w_bytes = 3'd4;
      endcase
      return w_bytes;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// ---------------------------------------------------------------------------
// lsu_lane_align
// Combinational byte-lane steering between the core and a 32-bit memory.
//   i_size       access size
//   i_offset     address bits [1:0]
//   i_signed     sign-extend narrow loads
//   i_store_data LSB-aligned store data from the core
//   i_mem_rdata  raw word read from memory
//   o_load_data  extracted, extended load result
//   o_store_data store data moved onto its byte lanes
//   o_wstrb      byte-lane write strobe for the store
// ---------------------------------------------------------------------------
module lsu_lane_align
   import lsu_pkg::*;
(
   input  lsu_size_t   i_size,
   input  logic [1:0]  i_offset,
   input  logic        i_signed,
   input  logic [31:0] i_store_data,
   input  logic [31:0] i_mem_rdata,
   output logic [31:0] o_load_data,
   output logic [31:0] o_store_data,
   output logic [3:0]  o_wstrb
);

   logic [31:0] w_shifted;

   // Bring the addressed byte lane down to bit 0.
   assign w_shifted    = i_mem_rdata >> {i_offset, 3'b000};
   assign o_store_data = i_store_data << {i_offset, 3'b000};

   // A word result has no spare bits, so the signed flag has no effect there.
   always_comb begin
      o_load_data = '0;
      case (i_size)
         SZ_BYTE: o_load_data = {{24{i_signed & w_shifted[7]}},  w_shifted[7:0]};
         SZ_HALF: o_load_data = {{16{i_signed & w_shifted[15]}}, w_shifted[15:0]};
         SZ_WORD: o_load_data = w_shifted;
         default: o_load_data = '0;
      endcase
   end

   always_comb begin
      o_wstrb = 4'b0000;
      case (i_size)
         SZ_BYTE: o_wstrb = 4'b0001 << i_offset;
         SZ_HALF: o_wstrb = 4'b0011 << i_offset;
         SZ_WORD: o_wstrb = 4'b1111;
         default: o_wstrb = 4'b0000;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Single-outstanding load/store unit between a core request/response port
// and a 32-bit memory with combinational read and falling-edge write.
//   iwClk, iwnRst                      clock, async active-low reset
//   iwReqValid/owReqReady              request handshake
//   iwReqWrite/Size/Signed/Addr/WData  request fields
//   owRespValid/iwRespReady            response handshake
//   owRespRData, owRespFault           response payload
//   owMemReadAddr, iwMemReadData       memory read port
//   owMemWriteAddr/WriteData/Wstrb     memory write port
// Flow: IDLE -(ok)-> ACCESS -> RESP -> IDLE, or IDLE -(fault)-> RESP.
// ---------------------------------------------------------------------------
module load_store_unit
   import lsu_pkg::*;
#(
   parameter logic [31:0] pMemBytes = 32'd176
)
(
   input  logic        iwClk,
   input  logic        iwnRst,
   input  logic        iwReqValid,
   output logic        owReqReady,
   input  logic        iwReqWrite,
   input  logic [1:0]  iwReqSize,
   input  logic        iwReqSigned,
   input  logic [31:0] iwReqAddr,
   input  logic [31:0] iwReqWData,
   output logic        owRespValid,
   input  logic        iwRespReady,
   output logic [31:0] owRespRData,
   output logic        owRespFault,
   output logic [31:0] owMemReadAddr,
   output logic [31:0] owMemWriteAddr,
   output logic [31:0] owMemWriteData,
   output logic [3:0]  owMemWstrb,
   input  logic [31:0] iwMemReadData
);

   lsu_state_t  r_state;
   lsu_state_t  w_state_next;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_rdata;
   lsu_size_t   r_size;
   logic        r_signed;
   logic        r_write;
   logic        r_fault;

   lsu_size_t   w_req_size;
   logic [32:0] w_end;
   logic        w_fault;
   logic [31:0] w_load_data;
   logic [31:0] w_store_data;
   logic [3:0]  w_wstrb;

   assign w_req_size = lsu_size_t'(iwReqSize);

   // One past the last byte touched; 33 bits so addresses near 2^32 cannot
   // wrap back into range.
   assign w_end = {1'b0, iwReqAddr} + {30'd0, size_bytes(w_req_size)};

   assign w_fault = (w_req_size == SZ_RSVD)
                 || ((w_req_size == SZ_HALF) && iwReqAddr[0])
                 || ((w_req_size == SZ_WORD) && (iwReqAddr[1:0] != 2'b00))
                 || (w_end > {1'b0, pMemBytes});

   lsu_lane_align u_lane_align (
      .i_size       (r_size),
      .i_offset     (r_addr[1:0]),
      .i_signed     (r_signed),
      .i_store_data (r_wdata),
      .i_mem_rdata  (iwMemReadData),
      .o_load_data  (w_load_data),
      .o_store_data (w_store_data),
      .o_wstrb      (w_wstrb)
   );

   always_ff @(posedge iwClk or negedge iwnRst) begin
      if (!iwnRst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Every memory-side output is decoded from r_state, so the async reset of
   // r_state removes the write strobe immediately.
   always_comb begin
      w_state_next   = r_state;
      owReqReady     = 1'b0;
      owRespValid    = 1'b0;
      owRespRData    = '0;
      owRespFault    = 1'b0;
      owMemReadAddr  = '0;
      owMemWriteAddr = '0;
      owMemWriteData = '0;
      owMemWstrb     = 4'b0000;
      case (r_state)
         ST_IDLE: begin
            owReqReady = 1'b1;
            if (iwReqValid) begin
               w_state_next = w_fault ? ST_RESP : ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            owMemReadAddr  = {r_addr[31:2], 2'b00};
            owMemWriteAddr = {r_addr[31:2], 2'b00};
            if (r_write) begin
               owMemWriteData = w_store_data;
               owMemWstrb     = w_wstrb;
            end
            w_state_next = ST_RESP;
         end
         ST_RESP: begin
            owRespValid = 1'b1;
            owRespRData = r_rdata;
            owRespFault = r_fault;
            if (iwRespReady) begin
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge iwClk or negedge iwnRst) begin
      if (!iwnRst) begin
         r_addr   <= '0;
         r_wdata  <= '0;
         r_rdata  <= '0;
         r_size   <= SZ_BYTE;
         r_signed <= 1'b0;
         r_write  <= 1'b0;
         r_fault  <= 1'b0;
      end else if ((r_state == ST_IDLE) && iwReqValid) begin
         r_addr   <= iwReqAddr;
         r_wdata  <= iwReqWData;
         r_size   <= w_req_size;
         r_signed <= iwReqSigned;
         r_write  <= iwReqWrite;
         r_fault  <= w_fault;
         r_rdata  <= '0;
      end else if (r_state == ST_ACCESS) begin
         r_rdata <= r_write ? 32'd0 : w_load_data;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
// Randomised and directed stimulus against a transaction-level model of the
// load/store unit backed by a byte-array memory image.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

   localparam int MEM_BYTES = 176;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        iwReqValid = 1'b0;
   logic        owReqReady;
   logic        iwReqWrite = 1'b0;
   logic [1:0]  iwReqSize = 2'b00;
   logic        iwReqSigned = 1'b0;
   logic [31:0] iwReqAddr = '0;
   logic [31:0] iwReqWData = '0;
   logic        owRespValid;
   logic        iwRespReady = 1'b0;
   logic [31:0] owRespRData;
   logic        owRespFault;
   logic [31:0] owMemReadAddr;
   logic [31:0] owMemWriteAddr;
   logic [31:0] owMemWriteData;
   logic [3:0]  owMemWstrb;
   logic [31:0] iwMemReadData;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   load_store_unit #(.pMemBytes(32'd176)) dut (
      .iwClk          (clk),
      .iwnRst         (rst_n),
      .iwReqValid     (iwReqValid),
      .owReqReady     (owReqReady),
      .iwReqWrite     (iwReqWrite),
      .iwReqSize      (iwReqSize),
      .iwReqSigned    (iwReqSigned),
      .iwReqAddr      (iwReqAddr),
      .iwReqWData     (iwReqWData),
      .owRespValid    (owRespValid),
      .iwRespReady    (iwRespReady),
      .owRespRData    (owRespRData),
      .owRespFault    (owRespFault),
      .owMemReadAddr  (owMemReadAddr),
      .owMemWriteAddr (owMemWriteAddr),
      .owMemWriteData (owMemWriteData),
      .owMemWstrb     (owMemWstrb),
      .iwMemReadData  (iwMemReadData)
   );

   // ---------------- memory seen by the DUT ----------------
   function automatic logic [7:0] init_byte(input int i);
      logic [7:0] b;
      case (i)
         0:       b = 8'h34;
         1:       b = 8'h12;
         2:       b = 8'h01;
         3:       b = 8'h80;
         default: b = 8'((i * 37 + 11) & 255);
      endcase
      return b;
   endfunction

   logic [7:0] mem [0:MEM_BYTES-1];

   always_comb begin
      iwMemReadData = '0;
      for (int k = 0; k < 4; k++) begin
         if (longint'(owMemReadAddr) + k < MEM_BYTES)
            iwMemReadData[8*k +: 8] = mem[int'(longint'(owMemReadAddr) + k)];
      end
   end

   initial begin
      for (int i = 0; i < MEM_BYTES; i++) mem[i] = init_byte(i);
      forever begin
         @(negedge clk);
         for (int k = 0; k < 4; k++) begin
            if (owMemWstrb[k] && (longint'(owMemWriteAddr) + k < MEM_BYTES))
               mem[int'(longint'(owMemWriteAddr) + k)] = owMemWriteData[8*k +: 8];
         end
      end
   end

   // ---------------- behavioural model ----------------
   function automatic int nbytes(input logic [1:0] sz);
      return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
   endfunction

   function automatic logic calc_fault(input logic [1:0] sz, input logic [31:0] a);
      if (sz == 2'b11) return 1'b1;
      if (sz == 2'b01 && (a % 2) != 0) return 1'b1;
      if (sz == 2'b10 && (a % 4) != 0) return 1'b1;
      if (longint'(a) + nbytes(sz) > MEM_BYTES) return 1'b1;
      return 1'b0;
   endfunction

   logic [7:0]  ref_mem [0:MEM_BYTES-1];
   int          m_phase = 0;   // 0 waiting for request, 1 memory cycle, 2 response pending
   logic        m_write = 1'b0;
   logic        m_signed = 1'b0;
   logic        m_fault = 1'b0;
   logic [1:0]  m_size = 2'b00;
   logic [31:0] m_addr = '0;
   logic [31:0] m_wdata = '0;
   logic [31:0] m_rdata = '0;

   initial begin
      for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = init_byte(i);
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_phase = 0;
            m_rdata = '0;
            m_fault = 1'b0;
         end else begin
            case (m_phase)
               0: if (iwReqValid) begin
                  m_write  = iwReqWrite;
                  m_size   = iwReqSize;
                  m_signed = iwReqSigned;
                  m_addr   = iwReqAddr;
                  m_wdata  = iwReqWData;
                  m_fault  = calc_fault(iwReqSize, iwReqAddr);
                  m_rdata  = '0;
                  m_phase  = m_fault ? 2 : 1;
               end
               1: begin
                  int n;
                  n = nbytes(m_size);
                  if (m_write) begin
                     for (int i = 0; i < n; i++)
                        ref_mem[int'(m_addr) + i] = m_wdata[8*i +: 8];
                  end else begin
                     logic [31:0] v;
                     v = '0;
                     for (int i = 0; i < n; i++)
                        v = v | (32'(ref_mem[int'(m_addr) + i]) << (8 * i));
                     if (m_signed && n < 4 && v[8*n-1])
                        v = v | (32'hFFFF_FFFF << (8 * n));
                     m_rdata = v;
                  end
                  m_phase = 2;
               end
               default: if (iwRespReady) m_phase = 0;
            endcase
         end
      end
   end

   // ---------------- comparison helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] exp_strb(input int off, input int n);
      logic [3:0] s;
      s = '0;
      for (int k = 0; k < 4; k++) if (k >= off && k < off + n) s[k] = 1'b1;
      return s;
   endfunction

   // Per-cycle comparison of every output against the model; all negedge
   // waits of the stimulus go through here.
   task automatic cycle();
      @(negedge clk);
      chk("req_ready", 32'(owReqReady), 32'(m_phase == 0));
      chk("resp_valid", 32'(owRespValid), 32'(m_phase == 2));
      if (!rst_n) begin
         chk("rst_rdata", owRespRData, 32'd0);
         chk("rst_fault", 32'(owRespFault), 32'd0);
         chk("rst_wdata", owMemWriteData, 32'd0);
      end else if (m_phase == 2) begin
         chk("resp_rdata", owRespRData, m_rdata);
         chk("resp_fault", 32'(owRespFault), 32'(m_fault));
      end
      if (m_phase == 1) begin
         chk("mem_raddr", owMemReadAddr, m_addr & ~32'd3);
         chk("mem_waddr", owMemWriteAddr, m_addr & ~32'd3);
         if (m_write) begin
            chk("mem_wstrb", 32'(owMemWstrb), 32'(exp_strb(int'(m_addr % 4), nbytes(m_size))));
            chk("mem_wdata", owMemWriteData, m_wdata << (8 * (m_addr % 4)));
         end else begin
            chk("mem_wstrb_load", 32'(owMemWstrb), 32'd0);
         end
      end else begin
         chk("idle_raddr", owMemReadAddr, 32'd0);
         chk("idle_waddr", owMemWriteAddr, 32'd0);
         chk("idle_wstrb", 32'(owMemWstrb), 32'd0);
      end
   endtask

   logic [3:0]  cap_wstrb;
   logic [31:0] cap_waddr, cap_wdata, cap_rdata;
   logic        cap_fault;
   int          cap_lat;

   // Issues one request from just after a falling edge and completes its
   // response, holding iwRespReady low for `hold` response cycles.
   task automatic run_req(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] d, input int hold);
      int n;
      int lat;
      iwReqValid  = 1'b1;
      iwReqWrite  = w;
      iwReqSize   = sz;
      iwReqSigned = sg;
      iwReqAddr   = a;
      iwReqWData  = d;
      n = 0;
      while (!owReqReady && n < 20) begin
         cycle();
         n++;
      end
      if (!owReqReady) chk("req_ready_timeout", 32'(owReqReady), 32'd1);
      @(posedge clk);
      cycle();
      iwReqValid = 1'b0;
      cap_wstrb = owMemWstrb;
      cap_waddr = owMemWriteAddr;
      cap_wdata = owMemWriteData;
      lat = 1;
      while (!owRespValid && lat < 8) begin
         cycle();
         lat++;
      end
      if (!owRespValid) chk("resp_timeout", 32'(owRespValid), 32'd1);
      cap_lat   = lat;
      cap_rdata = owRespRData;
      cap_fault = owRespFault;
      for (int h = 0; h < hold; h++) begin
         cycle();
         chk("hold_rdata", owRespRData, cap_rdata);
         chk("hold_fault", 32'(owRespFault), 32'(cap_fault));
         chk("hold_ready", 32'(owReqReady), 32'd0);
         chk("hold_valid", 32'(owRespValid), 32'd1);
      end
      iwRespReady = 1'b1;
      cycle();
      iwRespReady = 1'b0;
      $display("txn w=%0d sz=%0d s=%0d addr=%h wdata=%h -> rdata=%h fault=%0d lat=%0d",
               w, sz, sg, a, d, cap_rdata, cap_fault, cap_lat);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] old_word;
      logic [31:0] a;
      logic [1:0]  sz;
      int          n;

      #3;
      chk("reset_ready", 32'(owReqReady), 32'd1);
      chk("reset_valid", 32'(owRespValid), 32'd0);
      chk("reset_wstrb", 32'(owMemWstrb), 32'd0);
      chk("reset_rdata", owRespRData, 32'd0);
      cycle();
      cycle();
      rst_n = 1'b1;
      cycle();

      // Byte store then signed byte load at 0x05.
      run_req(1'b1, 2'b00, 1'b0, 32'h05, 32'h0000_00AB, 0);
      chk("bst_wstrb", 32'(cap_wstrb), 32'b0010);
      chk("bst_waddr", cap_waddr, 32'h04);
      chk("bst_wdata", cap_wdata, 32'h0000_AB00);
      chk("bst_lat", 32'(cap_lat), 32'd2);
      run_req(1'b0, 2'b00, 1'b1, 32'h05, 32'h0, 0);
      chk("bld_signed", cap_rdata, 32'hFFFF_FFAB);

      // Half loads from the word 0x8001_1234 at 0x00.
      run_req(1'b0, 2'b01, 1'b0, 32'h02, 32'h0, 0);
      chk("hld_unsigned", cap_rdata, 32'h0000_8001);
      run_req(1'b0, 2'b01, 1'b1, 32'h02, 32'h0, 0);
      chk("hld_signed", cap_rdata, 32'hFFFF_8001);
      run_req(1'b0, 2'b10, 1'b1, 32'h00, 32'h0, 0);
      chk("wld_signed_ignored", cap_rdata, 32'h8001_1234);

      // Misaligned word load faults after one edge with no memory access.
      run_req(1'b0, 2'b10, 1'b0, 32'h02, 32'h0, 0);
      chk("mis_fault", 32'(cap_fault), 32'd1);
      chk("mis_lat", 32'(cap_lat), 32'd1);
      chk("mis_wstrb", 32'(cap_wstrb), 32'd0);
      chk("mis_rdata", cap_rdata, 32'd0);

      // Range boundary.
      run_req(1'b1, 2'b10, 1'b0, 32'hAC, 32'hDEAD_BEEF, 0);
      chk("ac_fault", 32'(cap_fault), 32'd0);
      chk("ac_lat", 32'(cap_lat), 32'd2);
      chk("ac_wstrb", 32'(cap_wstrb), 32'hF);
      chk("ac_waddr", cap_waddr, 32'hAC);
      run_req(1'b1, 2'b10, 1'b0, 32'hB0, 32'h1234_5678, 0);
      chk("b0_fault", 32'(cap_fault), 32'd1);
      chk("b0_lat", 32'(cap_lat), 32'd1);
      run_req(1'b0, 2'b00, 1'b0, 32'hAF, 32'h0, 0);
      chk("af_fault", 32'(cap_fault), 32'd0);
      run_req(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'h0, 0);
      chk("wrap_fault", 32'(cap_fault), 32'd1);
      run_req(1'b0, 2'b11, 1'b0, 32'h00, 32'h0, 0);
      chk("rsvd_fault", 32'(cap_fault), 32'd1);

      // Response held for 5 cycles.
      run_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 5);
      chk("hold_lat", 32'(cap_lat), 32'd2);
      chk("after_hold_ready", 32'(owReqReady), 32'd1);

      // Reset pulsed during the memory cycle of a word store.
      old_word = {mem[19], mem[18], mem[17], mem[16]};
      iwReqValid  = 1'b1;
      iwReqWrite  = 1'b1;
      iwReqSize   = 2'b10;
      iwReqSigned = 1'b0;
      iwReqAddr   = 32'h10;
      iwReqWData  = ~old_word;
      n = 0;
      while (!owReqReady && n < 20) begin
         cycle();
         n++;
      end
      @(posedge clk);
      #2;
      chk("rst_pre_wstrb", 32'(owMemWstrb), 32'hF);
      rst_n = 1'b0;
      #1;
      chk("rst_async_wstrb", 32'(owMemWstrb), 32'd0);
      chk("rst_async_ready", 32'(owReqReady), 32'd1);
      chk("rst_async_waddr", owMemWriteAddr, 32'd0);
      iwReqValid = 1'b0;
      cycle();
      cycle();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("rst_no_resp", 32'(owRespValid), 32'd0);
      end
      chk("rst_mem_unchanged", {mem[19], mem[18], mem[17], mem[16]}, old_word);

      // Random traffic.
      for (int t = 0; t < 200; t++) begin
         sz = 2'($urandom_range(0, 3));
         a  = 32'($urandom_range(0, 183));
         if ($urandom_range(0, 3) != 0) a = a & ~32'(nbytes(sz) - 1);
         run_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
                 $urandom, int'($urandom_range(0, 2)));
         if ($urandom_range(0, 1) == 1) cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter pMemBytes, default 32'd176, the byte size of the downstream memory; any access reaching byte pMemBytes or above faults.
REQ-002 iwClk  in  1  clock; the block's state changes on the rising edge only.
REQ-003 iwnRst  in  1  reset, asynchronous, active-low.
REQ-004 iwReqValid  in  1  the core presents a request.
REQ-005 owReqReady  out  1  the block accepts a request.
REQ-006 iwReqWrite  in  1  1 = store, 0 = load.
REQ-007 iwReqSize  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
REQ-008 iwReqSigned  in  1  sign-extend the load result.
REQ-009 iwReqAddr  in  32  byte address.
REQ-010 iwReqWData  in  32  store data, taken from the low bits (LSB-aligned).
REQ-011 owRespValid  out  1  a response is pending.
REQ-012 iwRespReady  in  1  the core accepts the response.
REQ-013 owRespRData  out  32  load result; 0 for stores and for faults.
REQ-014 owRespFault  out  1  the request was misaligned, out of range or had reserved size.
REQ-015 owMemReadAddr  out  32  word-aligned read address to the memory.
REQ-016 owMemWriteAddr  out  32  word-aligned write address to the memory.
REQ-017 owMemWriteData  out  32  lane-positioned store data.
REQ-018 owMemWstrb  out  4  byte-lane write strobe.
REQ-019 iwMemReadData  in  32  combinational read data returned from owMemReadAddr.

Function
REQ-020 SHALL implement an FSM with states IDLE, ACCESS and RESP.
REQ-021 owReqReady SHALL be 1 exactly in IDLE.
REQ-022 A handshake SHALL occur when iwReqValid and owReqReady are both 1 at a rising edge; the block then registers the address, size, signed flag, write flag and data.
REQ-023 On handshake: fault check passes -> ACCESS; fault check fails -> RESP with owRespFault=1, and no memory access occurs.
REQ-024 The fault check SHALL fire on any of:
- iwReqSize=11;
- half with addr[0]=1;
- word with addr[1:0]!=0;
- addr + access_bytes > pMemBytes, computed in 33-bit arithmetic so it cannot wrap.
REQ-025 In ACCESS, owMemReadAddr and owMemWriteAddr SHALL equal {addr[31:2],2'b00}; outside ACCESS both SHALL hold 0.
REQ-026 For a store in ACCESS, owMemWstrb SHALL be:
- byte: 4'b0001<<addr[1:0];
- half: 4'b0011<<addr[1:0];
- word: 4'b1111.
REQ-027 For a store in ACCESS, owMemWriteData SHALL be the store data shifted left by 8*addr[1:0] bits.
REQ-028 owMemWstrb SHALL be 0 in every state other than ACCESS-with-store, and SHALL be driven from registered state so that it is stable at the memory's falling-edge write.
REQ-029 ACCESS SHALL last exactly one cycle; at its closing rising edge the block moves to RESP.
REQ-030 At that same edge, a load SHALL capture iwMemReadData>>(8*addr[1:0]), masked to the access size, zero- or sign-extended per the signed flag.
REQ-031 Latency: owRespValid SHALL rise 2 edges after the handshake on success, or 1 edge after on a fault.
REQ-032 In RESP, owRespValid=1; owRespRData and owRespFault SHALL hold stable until iwRespReady=1 at a rising edge, after which the block returns to IDLE.
REQ-033 Throughput SHALL be at most one request per 3 cycles; there is no request overlap.
REQ-034 A signed flag on a word access or on a store SHALL be ignored.

Reset
REQ-035 While iwnRst=0, the block SHALL be in IDLE and every output SHALL be 0 except owReqReady, which is 1.
REQ-036 Reset asserted during ACCESS SHALL force owMemWstrb to 0 immediately (asynchronously), so no partial write occurs.
REQ-037 A request pending at reset SHALL be discarded, and no response is issued for it.

Structure
REQ-038 A shared package lsu_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD) and the FSM state encodings.
REQ-039 A sub-module lsu_lane_align SHALL hold the combinational load extract/extend and store shift/strobe logic.

Verification
REQ-040 Byte store: 0x000000AB to address 0x05 -> wstrb 0010, write address 0x04, write data 0x0000AB00; a following signed byte load at 0x05 returns 0xFFFFFFAB.
REQ-041 Half load at 0x02 with memory word 0x8001_1234: unsigned returns 0x00008001; signed returns 0xFFFF8001.
REQ-042 Word load at 0x02 -> fault response 1 edge after the handshake; wstrb stays 0 throughout; owRespRData=0.
REQ-043 Word store at 0xAC with pMemBytes=176 succeeds; word store at 0xB0 faults.
REQ-044 iwRespReady held low for 5 cycles -> response stable and owReqReady=0 throughout; the next request is accepted only after the response handshake.
REQ-045 iwnRst pulsed low mid-ACCESS of a word store -> wstrb drops to 0 at once, the memory is unchanged, and the block returns to IDLE with no response.
